// File: rtl/ysyx_040066_trap_ctrl_if.sv
// ysyx_040066_trap_ctrl_if
// Bundles the signals between the writeback stage / CSR unit and the trap
// sequencer.
//   master : pipeline/CSR side; drives exception, mret, commit and
//            register-write requests, and receives trap pulses and timer state.
//   slave  : trap sequencer side (ysyx_040066_trap_ctrl).
// clk/rst are not part of the bundle.
interface ysyx_040066_trap_ctrl_if;
  // requests from writeback / CSR
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [63:0] exc_tval;
  logic [63:0] exc_pc;
  logic        is_mret;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        mstatus_mie;
  logic        mie_mtie;
  logic        pipe_idle;
  logic        cmp_wen;
  logic [63:0] cmp_wdata;
  logic        time_wen;
  logic [63:0] time_wdata;
  // results to the CSR unit / pipeline
  logic        raise_intr;
  logic [63:0] NO;
  logic [63:0] tval;
  logic [63:0] pc;
  logic        ret;
  logic        clear_mip;
  logic        flush;
  logic        stall;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        timer_pending;

  modport master (
    output exc_valid, exc_code, exc_tval, exc_pc, is_mret, commit_valid,
           commit_pc, mstatus_mie, mie_mtie, pipe_idle, cmp_wen, cmp_wdata,
           time_wen, time_wdata,
    input  raise_intr, NO, tval, pc, ret, clear_mip, flush, stall, mtime,
           mtimecmp, timer_pending
  );

  modport slave (
    input  exc_valid, exc_code, exc_tval, exc_pc, is_mret, commit_valid,
           commit_pc, mstatus_mie, mie_mtie, pipe_idle, cmp_wen, cmp_wdata,
           time_wen, time_wdata,
    output raise_intr, NO, tval, pc, ret, clear_mip, flush, stall, mtime,
           mtimecmp, timer_pending
  );
endinterface

// File: rtl/ysyx_040066_trap_ctrl.sv
// ysyx_040066_trap_ctrl
// Trap sequencer and machine timer. Arbitrates a writeback exception, an mret
// and the machine timer interrupt (in that priority), drains the pipeline
// before a trap, then issues a single raise_intr or ret pulse together with
// the captured cause/tval/pc. Also owns mtime/mtimecmp, the timer-pending
// compare and the clear_mip pulse that follows an mtimecmp write.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : ysyx_040066_trap_ctrl_if.slave (requests in, trap/timer state out)
// Parameter:
//   TIMER_DIV : mtime increments once every TIMER_DIV cycles (>= 1)
module ysyx_040066_trap_ctrl #(
  parameter int unsigned TIMER_DIV = 1
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_040066_trap_ctrl_if.slave bus
);

  localparam int unsigned   PW         = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);
  localparam logic [63:0]   TIMER_CAUSE = 64'h8000_0000_0000_0007;

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP, RET} state_t;

  state_t        state_reg, state_next;
  logic [63:0]   no_reg, tval_reg, pc_reg;
  logic [63:0]   mtime_reg, mtimecmp_reg;
  logic [PW-1:0] presc_reg;
  logic          clear_mip_reg;

  logic in_idle, take_exc, take_mret, take_irq, timer_pending;
  logic raise_intr, ret, flush, stall;

  assign timer_pending = (mtime_reg >= mtimecmp_reg);

  // Requests are only looked at in IDLE; upstream holds them under stall.
  assign in_idle   = (state_reg == IDLE);
  assign take_exc  = in_idle & bus.exc_valid;
  assign take_mret = in_idle & ~bus.exc_valid & bus.is_mret;
  assign take_irq  = in_idle & ~bus.exc_valid & ~bus.is_mret & bus.commit_valid
                   & bus.mstatus_mie & bus.mie_mtie & timer_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and Moore-decoded pulses.
  always_comb begin
    state_next = state_reg;
    raise_intr = 1'b0;
    ret        = 1'b0;
    flush      = 1'b0;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (take_exc || take_irq) begin
          state_next = DRAIN;
        end else if (take_mret) begin
          state_next = RET;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (bus.pipe_idle) begin
          state_next = TRAP;
        end
      end
      TRAP: begin
        raise_intr = 1'b1;
        flush      = 1'b1;
        stall      = 1'b1;
        state_next = IDLE;
      end
      RET: begin
        ret        = 1'b1;
        flush      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Trap information is captured on DRAIN entry and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      no_reg   <= '0;
      tval_reg <= '0;
      pc_reg   <= '0;
    end else if (take_exc) begin
      no_reg   <= {60'b0, bus.exc_code};
      tval_reg <= bus.exc_tval;
      pc_reg   <= bus.exc_pc;
    end else if (take_irq) begin
      no_reg   <= TIMER_CAUSE;
      tval_reg <= '0;
      pc_reg   <= bus.commit_pc;
    end
  end

  // mtime with prescaler; a software write beats a coincident increment and
  // restarts the prescale period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_reg <= '0;
      presc_reg <= '0;
    end else if (bus.time_wen) begin
      mtime_reg <= bus.time_wdata;
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      mtime_reg <= mtime_reg + 64'd1;
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp_reg  <= '1;
      clear_mip_reg <= 1'b0;
    end else begin
      clear_mip_reg <= bus.cmp_wen;
      if (bus.cmp_wen) begin
        mtimecmp_reg <= bus.cmp_wdata;
      end
    end
  end

  assign bus.raise_intr    = raise_intr;
  assign bus.ret           = ret;
  assign bus.flush         = flush;
  assign bus.stall         = stall;
  assign bus.NO            = no_reg;
  assign bus.tval          = tval_reg;
  assign bus.pc            = pc_reg;
  assign bus.clear_mip     = clear_mip_reg;
  assign bus.mtime         = mtime_reg;
  assign bus.mtimecmp      = mtimecmp_reg;
  assign bus.timer_pending = timer_pending;

endmodule

// File: tb/tb_ysyx_040066_trap_ctrl.sv
module tb_ysyx_040066_trap_ctrl;

  localparam logic [63:0] TIMER_CAUSE = 64'h8000_0000_0000_0007;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  ysyx_040066_trap_ctrl_if bus ();
  ysyx_040066_trap_ctrl_if bus2 ();

  ysyx_040066_trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Second instance only exercises the mtime prescaler.
  ysyx_040066_trap_ctrl #(.TIMER_DIV(3)) dut_div3 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exc_valid = 0;  bus.exc_code = '0; bus.exc_tval = '0; bus.exc_pc = '0;
    bus.is_mret = 0;    bus.commit_valid = 0; bus.commit_pc = '0;
    bus.mstatus_mie = 0; bus.mie_mtie = 0; bus.pipe_idle = 1;
    bus.cmp_wen = 0;    bus.cmp_wdata = '0; bus.time_wen = 0; bus.time_wdata = '0;
    bus2.exc_valid = 0; bus2.exc_code = '0; bus2.exc_tval = '0; bus2.exc_pc = '0;
    bus2.is_mret = 0;   bus2.commit_valid = 0; bus2.commit_pc = '0;
    bus2.mstatus_mie = 0; bus2.mie_mtie = 0; bus2.pipe_idle = 1;
    bus2.cmp_wen = 0;   bus2.cmp_wdata = '0; bus2.time_wen = 0; bus2.time_wdata = '0;
  endtask

  // Leaves the bench #1 after a rising edge at "cycle 0", mtime still 0.
  task automatic reset_dut();
    rst = 1;
    idle_inputs();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    step();
    tests_run++;
    if (bus.mtime !== 64'd0 || bus.mtimecmp !== '1 || bus.timer_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_timer got mtime=%h cmp=%h pend=%b exp 0/ffff.../0",
               bus.mtime, bus.mtimecmp, bus.timer_pending);
    end
    tests_run++;
    if ({bus.NO, bus.tval, bus.pc} !== '0 || bus.clear_mip !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_capture got NO=%h tval=%h pc=%h clr=%b exp all 0",
               bus.NO, bus.tval, bus.pc, bus.clear_mip);
    end
    tests_run++;
    if ({bus.raise_intr, bus.ret, bus.flush, bus.stall} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses got %b exp 0000",
               {bus.raise_intr, bus.ret, bus.flush, bus.stall});
    end
    rst = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests_run++;
      if (bus.mtime !== 64'(k) ||
          {bus.raise_intr, bus.ret, bus.flush, bus.stall, bus.clear_mip} !== 5'b0) begin
        tests_failed++;
        $display("FAIL idle_count k=%0d got mtime=%0d pulses=%b exp mtime=%0d pulses=0",
                 k, bus.mtime, {bus.raise_intr, bus.ret, bus.flush, bus.stall, bus.clear_mip}, k);
      end
    end
    tests_run++;
    if (bus.timer_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_pending got %b exp 0", bus.timer_pending);
    end
    $display("[TB] reset/idle: mtime=%0d", bus.mtime);
  endtask

  task automatic test_exception();
    reset_dut();
    bus.exc_valid = 1; bus.exc_code = 4'd2; bus.exc_tval = 64'hDEAD;
    bus.exc_pc = 64'h8000_0010; bus.pipe_idle = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      bus.exc_valid = 0;
      tests_run++;
      if (bus.stall !== (k <= 4) || bus.raise_intr !== (k == 4) ||
          bus.flush !== (k == 4) || bus.ret !== 1'b0) begin
        tests_failed++;
        $display("FAIL exc_seq k=%0d got stall=%b raise=%b flush=%b ret=%b exp %b %b %b 0",
                 k, bus.stall, bus.raise_intr, bus.flush, bus.ret, k <= 4, k == 4, k == 4);
      end
      if (k == 4) begin
        tests_run++;
        if (bus.NO !== 64'd2 || bus.tval !== 64'hDEAD || bus.pc !== 64'h8000_0010) begin
          tests_failed++;
          $display("FAIL exc_values got NO=%h tval=%h pc=%h exp 2/dead/80000010",
                   bus.NO, bus.tval, bus.pc);
        end
      end
      bus.pipe_idle = (k >= 3);
    end
    $display("[TB] exception: NO=%0d pc=%h", bus.NO, bus.pc);
  endtask

  task automatic test_timer_irq();
    reset_dut();
    bus.cmp_wen = 1; bus.cmp_wdata = 64'd20;
    bus.mstatus_mie = 1; bus.mie_mtie = 1;
    bus.commit_valid = 1; bus.commit_pc = 64'h8000_0100; bus.pipe_idle = 1;
    for (int c = 1; c <= 25; c++) begin
      step();
      bus.cmp_wen = 0;
      // mtime reaches the compare value at cycle 20; trap two cycles later
      tests_run++;
      if (bus.mtime !== 64'(c) || bus.clear_mip !== (c == 1) ||
          bus.raise_intr !== (c == 22) || bus.stall !== (c == 21 || c == 22)) begin
        tests_failed++;
        $display("FAIL tirq_seq c=%0d got mtime=%0d clr=%b raise=%b stall=%b exp %0d %b %b %b",
                 c, bus.mtime, bus.clear_mip, bus.raise_intr, bus.stall,
                 c, c == 1, c == 22, c == 21 || c == 22);
      end
      if (c == 22) begin
        tests_run++;
        if (bus.NO !== TIMER_CAUSE || bus.pc !== 64'h8000_0100 || bus.tval !== 64'd0) begin
          tests_failed++;
          $display("FAIL tirq_values got NO=%h pc=%h tval=%h exp %h/80000100/0",
                   bus.NO, bus.pc, bus.tval, TIMER_CAUSE);
        end
        bus.commit_valid = 0;
      end
    end
    $display("[TB] timer irq: NO=%h pc=%h", bus.NO, bus.pc);
  endtask

  task automatic test_priority();
    int n_raise;
    int n_ret;
    n_raise = 0;
    n_ret = 0;
    reset_dut();
    bus.cmp_wen = 1; bus.cmp_wdata = 64'd0;
    step();
    bus.cmp_wen = 0;
    bus.exc_valid = 1; bus.exc_code = 4'd11; bus.exc_tval = 64'h55; bus.exc_pc = 64'h1234;
    bus.is_mret = 1; bus.commit_valid = 1; bus.commit_pc = 64'h9999;
    bus.mstatus_mie = 1; bus.mie_mtie = 1;
    tests_run++;
    if (bus.timer_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL prio_pending got %b exp 1", bus.timer_pending);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      bus.exc_valid = 0; bus.is_mret = 0; bus.commit_valid = 0;
      if (bus.raise_intr) begin
        n_raise++;
        tests_run++;
        if (bus.NO !== 64'd11 || bus.pc !== 64'h1234) begin
          tests_failed++;
          $display("FAIL prio_values got NO=%h pc=%h exp b/1234", bus.NO, bus.pc);
        end
      end
      if (bus.ret) n_ret++;
    end
    tests_run++;
    if (n_raise !== 1 || n_ret !== 0) begin
      tests_failed++;
      $display("FAIL prio_count got raise=%0d ret=%0d exp 1/0", n_raise, n_ret);
    end
    $display("[TB] priority: raises=%0d rets=%0d", n_raise, n_ret);
  endtask

  task automatic test_mret_masked();
    reset_dut();
    bus.cmp_wen = 1; bus.cmp_wdata = 64'd0;
    bus.mstatus_mie = 0; bus.mie_mtie = 1; bus.commit_valid = 1;
    step();
    bus.cmp_wen = 0;
    bus.is_mret = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      bus.is_mret = 0;
      tests_run++;
      if (bus.ret !== (k == 1) || bus.flush !== (k == 1) || bus.stall !== 1'b0 ||
          bus.raise_intr !== 1'b0 || bus.timer_pending !== 1'b1) begin
        tests_failed++;
        $display("FAIL mret_seq k=%0d got ret=%b flush=%b stall=%b raise=%b pend=%b exp %b %b 0 0 1",
                 k, bus.ret, bus.flush, bus.stall, bus.raise_intr, bus.timer_pending, k == 1, k == 1);
      end
    end
    bus.commit_valid = 0;
    $display("[TB] mret + masked timer done");
  endtask

  task automatic test_reset_mid_drain();
    reset_dut();
    bus.exc_valid = 1; bus.exc_code = 4'd5; bus.pipe_idle = 0;
    step();
    bus.exc_valid = 0;
    tests_run++;
    if (bus.stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL rdrain_pre got stall=%b exp 1", bus.stall);
    end
    #2 rst = 1;
    #1;
    tests_run++;
    if (bus.stall !== 1'b0 || bus.flush !== 1'b0 || bus.mtime !== 64'd0 || bus.NO !== 64'd0) begin
      tests_failed++;
      $display("FAIL rdrain_async got stall=%b flush=%b mtime=%0d NO=%h exp 0 0 0 0",
               bus.stall, bus.flush, bus.mtime, bus.NO);
    end
    bus.pipe_idle = 1;
    step();
    step();
    rst = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (bus.raise_intr !== 1'b0 || bus.stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL rdrain_after k=%0d got raise=%b stall=%b exp 0 0", k, bus.raise_intr, bus.stall);
      end
    end
    $display("[TB] reset mid-drain done");
  endtask

  task automatic test_timer_regs();
    reset_dut();
    // write and a wrap coincide every cycle with TIMER_DIV=1
    bus.time_wen = 1; bus.time_wdata = '1;
    step();
    bus.time_wen = 0;
    tests_run++;
    if (bus.mtime !== '1 || bus.timer_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL treg_load got mtime=%h pend=%b exp ffffffffffffffff 1", bus.mtime, bus.timer_pending);
    end
    bus.cmp_wen = 1; bus.cmp_wdata = 64'h8000_0000_0000_0000;
    bus.time_wen = 1; bus.time_wdata = 64'd5;
    step();
    bus.cmp_wen = 0; bus.time_wen = 0;
    tests_run++;
    if (bus.mtime !== 64'd5 || bus.mtimecmp !== 64'h8000_0000_0000_0000 ||
        bus.timer_pending !== 1'b0 || bus.clear_mip !== 1'b1) begin
      tests_failed++;
      $display("FAIL treg_cmp got mtime=%0d cmp=%h pend=%b clr=%b exp 5 8000000000000000 0 1",
               bus.mtime, bus.mtimecmp, bus.timer_pending, bus.clear_mip);
    end
    bus.time_wen = 1; bus.time_wdata = '1;
    step();
    bus.time_wen = 0;
    step();
    tests_run++;
    if (bus.mtime !== 64'd0 || bus.clear_mip !== 1'b0 || bus.timer_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL treg_wrap got mtime=%h clr=%b pend=%b exp 0 0 0", bus.mtime, bus.clear_mip, bus.timer_pending);
    end
    $display("[TB] timer registers done");
  endtask

  task automatic test_prescaler();
    logic [63:0] exp_t;
    reset_dut();
    for (int c = 1; c <= 11; c++) begin
      step();
      exp_t = 64'(c / 3);
      tests_run++;
      if (bus2.mtime !== exp_t) begin
        tests_failed++;
        $display("FAIL presc_count c=%0d got %0d exp %0d", c, bus2.mtime, exp_t);
      end
    end
    // cycle 11 is a wrap cycle (third of a period); the write must win
    bus2.time_wen = 1; bus2.time_wdata = 64'd100;
    for (int j = 0; j <= 7; j++) begin
      step();
      bus2.time_wen = 0;
      exp_t = 64'd100 + 64'(j / 3);
      tests_run++;
      if (bus2.mtime !== exp_t) begin
        tests_failed++;
        $display("FAIL presc_write j=%0d got %0d exp %0d", j, bus2.mtime, exp_t);
      end
    end
    $display("[TB] prescaler div3: mtime=%0d", bus2.mtime);
  endtask

  task automatic drive_garbage();
    bus.exc_valid = 1'($urandom); bus.exc_code = 4'($urandom);
    bus.exc_tval = {$urandom, $urandom}; bus.exc_pc = {$urandom, $urandom};
    bus.is_mret = 1'($urandom); bus.commit_valid = 1'($urandom);
    bus.commit_pc = {$urandom, $urandom};
    bus.mstatus_mie = 1'($urandom); bus.mie_mtie = 1'($urandom);
  endtask

  task automatic test_random();
    logic [63:0] exp_no, exp_tval, exp_pc;
    int kind, d, len;
    bit is_trap, is_ret;
    exp_no = '0; exp_tval = '0; exp_pc = '0;
    reset_dut();
    bus.cmp_wen = 1; bus.cmp_wdata = 64'd0;  // timer always pending
    step();
    bus.cmp_wen = 0;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      d = $urandom_range(0, 3);
      drive_garbage();
      bus.exc_valid = (kind == 0);
      if (kind == 1) bus.is_mret = 1;
      if (kind == 2) begin
        bus.exc_valid = 0; bus.is_mret = 0;
      end
      bus.pipe_idle = 1'($urandom);
      // reference: exception > mret > enabled timer interrupt
      is_trap = 0; is_ret = 0;
      if (bus.exc_valid) begin
        is_trap = 1; exp_no = {60'b0, bus.exc_code}; exp_tval = bus.exc_tval; exp_pc = bus.exc_pc;
      end else if (bus.is_mret) begin
        is_ret = 1;
      end else if (bus.commit_valid && bus.mstatus_mie && bus.mie_mtie) begin
        is_trap = 1; exp_no = TIMER_CAUSE; exp_tval = '0; exp_pc = bus.commit_pc;
      end
      len = is_trap ? d + 3 : (is_ret ? 2 : 1);
      $display("[TB] txn %0d kind=%0d trap=%0b ret=%0b drain=%0d NO=%h pc=%h",
               t, kind, is_trap, is_ret, d, exp_no, exp_pc);
      for (int k = 1; k <= len; k++) begin
        step();
        tests_run++;
        if (bus.stall !== (is_trap && k <= d + 2) ||
            bus.raise_intr !== (is_trap && k == d + 2) ||
            bus.ret !== (is_ret && k == 1) ||
            bus.flush !== ((is_trap && k == d + 2) || (is_ret && k == 1)) ||
            bus.NO !== exp_no || bus.tval !== exp_tval || bus.pc !== exp_pc) begin
          tests_failed++;
          $display("FAIL rand t=%0d k=%0d got s/r/t/f=%b%b%b%b NO=%h tval=%h pc=%h exp %b%b%b%b %h %h %h",
                   t, k, bus.stall, bus.raise_intr, bus.ret, bus.flush, bus.NO, bus.tval, bus.pc,
                   is_trap && k <= d + 2, is_trap && k == d + 2, is_ret && k == 1,
                   (is_trap && k == d + 2) || (is_ret && k == 1), exp_no, exp_tval, exp_pc);
        end
        if (k < len) begin
          drive_garbage();  // ignored while not idle
          bus.pipe_idle = is_trap ? ((k >= d + 1) ? 1'b1 : 1'b0) : 1'($urandom);
          if (is_trap && k == d + 2) bus.pipe_idle = 1'($urandom);
        end else begin
          idle_inputs();
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exception();
    test_timer_irq();
    test_priority();
    test_mret_masked();
    test_reset_mid_drain();
    test_timer_regs();
    test_prescaler();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
